// File: rtl/instr_mem_dump_if.sv
// Bus bundle for instr_mem_dump: the synchronous memory read port plus the
// outgoing word stream.
interface instr_mem_dump_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data;

  // Stream handshake: a word transfers on a rising edge where out_valid &&
  // out_ready. Once raised, out_valid and its payload hold until that edge;
  // out_valid never depends on out_ready; out_ready is ignored while
  // out_valid is low.
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_last;

  modport master (
    output mem_rd_en, mem_rd_addr, out_valid, out_data, out_addr, out_last,
    input  mem_rd_data, out_ready
  );

  modport slave (
    input  mem_rd_en, mem_rd_addr, out_valid, out_data, out_addr, out_last,
    output mem_rd_data, out_ready
  );
endinterface

// File: rtl/instr_mem_dump.sv
// Instruction-memory readback engine: reads a contiguous, wrapping address
// range one word at a time and streams each word tagged with its address.
module instr_mem_dump #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  instr_mem_dump_if.master  bus,
  output logic              busy,
  output logic              done,
  output logic [2:0]        dbg_state
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] REM_ONE = (ADDR_W+1)'(1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ISSUE   = 3'd1;
  localparam logic [2:0] CAPTURE = 3'd2;
  localparam logic [2:0] OUT     = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  logic [2:0]        state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= '0;
      rem           <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_addr  <= '0;
      bus.out_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ptr   <= base_addr;
            rem   <= (count > DEPTH_W) ? DEPTH_W : count;
            state <= (count == '0) ? DONE : ISSUE;
          end
        end
        ISSUE: state <= CAPTURE;
        CAPTURE: begin
          // Read data is valid exactly one cycle after the ISSUE strobe.
          bus.out_data  <= bus.mem_rd_data;
          bus.out_addr  <= ptr;
          bus.out_last  <= (rem == REM_ONE);
          bus.out_valid <= 1'b1;
          state         <= OUT;
        end
        OUT: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            ptr           <= ptr + ADDR_W'(1);
            rem           <= rem - REM_ONE;
            state         <= (rem == REM_ONE) ? DONE : ISSUE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // ptr is reset to 0, so mem_rd_addr is 0 under reset as well.
  assign bus.mem_rd_en   = (state == ISSUE);
  assign bus.mem_rd_addr = ptr;
  assign busy            = (state != IDLE);
  assign done            = (state == DONE);
  assign dbg_state       = state;
endmodule

// File: tb/tb_instr_mem_dump.sv
// Bench for instr_mem_dump: memory model with load port, random ready,
// word-level reference queue built from the memory image.
module tb_instr_mem_dump;
  localparam int W = 38;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [4:0] base_addr = '0;
  logic [5:0] count = '0;
  logic       busy, done;
  logic [2:0] dbg_state;

  logic        load_mem_en = 1'b0;
  logic [4:0]  load_mem_addr = '0;
  logic [31:0] load_mem_data = '0;
  logic [31:0] mem [32];
  logic [31:0] ref_mem [32];

  int   rdy_mode = 0;
  logic man_ready = 1'b1;
  logic rnd_ready = 1'b1;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int start_cyc, last_hs_cyc;
  int words_seen, done_cnt, rd_cnt, busy_cnt;
  bit first_pending = 0;
  bit stall_prev = 0;
  logic [W-1:0] held;
  logic [W-1:0] exp_q[$];
  logic [4:0]   exp_rd_q[$];

  instr_mem_dump_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  instr_mem_dump #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / memory model / ready driver ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial bus.mem_rd_data = '0;
  always @(posedge clk) begin
    if (load_mem_en) mem[load_mem_addr] <= load_mem_data;
    if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_rd_addr];
  end

  always @(posedge clk) begin
    #1;
    rnd_ready = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
  end
  assign bus.out_ready = (rdy_mode == 2) ? man_ready : rnd_ready;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 0;
    end else begin
      if (busy) busy_cnt++;
      if (!bus.out_valid) chk("last_without_valid", 64'(bus.out_last), 64'd0);
      if (bus.mem_rd_en) begin
        rd_cnt++;
        if (exp_rd_q.size() == 0) chk("extra_read", 64'd1, 64'd0);
        else chk("rd_addr", 64'(bus.mem_rd_addr), 64'(exp_rd_q.pop_front()));
      end
      if (stall_prev) begin
        chk("hold_valid", 64'(bus.out_valid), 64'd1);
        chk("hold_payload", 64'({bus.out_last, bus.out_addr, bus.out_data}), 64'(held));
      end
      if (bus.out_valid && first_pending) begin
        chk("first_latency", 64'(cyc), 64'(start_cyc + 3));
        first_pending = 0;
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      held = {bus.out_last, bus.out_addr, bus.out_data};
      if (bus.out_valid && bus.out_ready) begin
        words_seen++;
        last_hs_cyc = cyc;
        if (exp_q.size() == 0) chk("extra_word", 64'd1, 64'd0);
        else chk("word", 64'({bus.out_last, bus.out_addr, bus.out_data}), 64'(exp_q.pop_front()));
      end
      if (done) begin
        done_cnt++;
        chk("done_timing", 64'(cyc), 64'(last_hs_cyc + 1));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load_mem(input bit randomize_data);
    @(posedge clk); #1;
    load_mem_en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      load_mem_addr = 5'(i);
      load_mem_data = randomize_data ? $urandom() : 32'h1000_0000 + 32'(i);
      ref_mem[i] = load_mem_data;
      @(posedge clk); #1;
    end
    load_mem_en = 1'b0;
  endtask

  task automatic arm_dump(input logic [4:0] b, input logic [5:0] c);
    int n;
    logic [4:0] a;
    n = (c > 6'd32) ? 32 : int'(c);
    exp_q.delete();
    exp_rd_q.delete();
    for (int i = 0; i < n; i++) begin
      a = 5'((int'(b) + i) % 32);
      exp_q.push_back({(i == n - 1), a, ref_mem[a]});
      exp_rd_q.push_back(a);
    end
    words_seen = 0; done_cnt = 0; rd_cnt = 0; busy_cnt = 0;
    @(posedge clk); #1;
    start_cyc = cyc;
    last_hs_cyc = cyc;
    first_pending = (n > 0);
    start = 1'b1; base_addr = b; count = c;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input logic [5:0] c);
    int n;
    int t;
    n = (c > 6'd32) ? 32 : int'(c);
    t = 0;
    while (done_cnt == 0 && t < 1500) begin
      @(posedge clk); #1;
      t++;
    end
    if (done_cnt == 0) chk("done_timeout", 64'd0, 64'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("word_count", 64'(words_seen), 64'(n));
    chk("done_pulses", 64'(done_cnt), 64'd1);
    chk("read_count", 64'(rd_cnt), 64'(n));
    chk("exp_left", 64'(exp_q.size()), 64'd0);
    chk("idle_after", 64'(busy), 64'd0);
    if (rdy_mode == 0) chk("busy_cycles", 64'(busy_cnt), 64'(3 * n + 1));
  endtask

  task automatic run_dump(input logic [4:0] b, input logic [5:0] c);
    arm_dump(b, c);
    wait_done(c);
  endtask

  task automatic wait_cond_valid(input string tag);
    int t;
    t = 0;
    while (!bus.out_valid && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!bus.out_valid) chk(tag, 64'd0, 64'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, 64'({bus.mem_rd_en, bus.mem_rd_addr, bus.out_valid, bus.out_data,
                  bus.out_addr, bus.out_last, busy, done, dbg_state}), 64'd0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int t;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset_state");
    rst_n = 1'b1;

    load_mem(1'b0);

    rdy_mode = 0;
    run_dump(5'd0, 6'd32);
    run_dump(5'd30, 6'd4);
    run_dump(5'd12, 6'd0);
    run_dump(5'd5, 6'd40);
    run_dump(5'd31, 6'd1);

    // Backpressure on the second word, plus a start pulse while busy.
    rdy_mode = 2;
    man_ready = 1'b1;
    arm_dump(5'd8, 6'd3);
    t = 0;
    while (words_seen < 1 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (words_seen < 1) chk("bp_first_word_timeout", 64'd0, 64'd1);
    man_ready = 1'b0;
    wait_cond_valid("bp_valid_timeout");
    for (int i = 0; i < 7; i++) begin
      start = (i == 2); base_addr = 5'd20; count = 6'd5;
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("bp_data", 64'(bus.out_data), 64'h1000_0009);
    chk("bp_addr", 64'(bus.out_addr), 64'd9);
    man_ready = 1'b1;
    wait_done(6'd3);

    // Reset while stalled in OUT aborts without a done pulse.
    man_ready = 1'b0;
    arm_dump(5'd3, 6'd10);
    wait_cond_valid("rst_valid_timeout");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    exp_q.delete();
    exp_rd_q.delete();
    first_pending = 0;
    done_cnt = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("no_done_after_abort", 64'(done_cnt), 64'd0);
    chk("idle_after_abort", 64'(dbg_state), 64'd0);

    rdy_mode = 1;
    run_dump(5'd17, 6'd9);

    // Random memory image and random dumps.
    load_mem(1'b1);
    for (int k = 0; k < 8; k++) begin
      rdy_mode = int'($urandom_range(0, 1));
      run_dump(5'($urandom_range(0, 31)), 6'($urandom_range(0, 63)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/instr_mem_dump.md
Name: instr_mem_dump

Overview:
Readback engine for the CPU's 32-word instruction memory. It reads the same storage that the load_mem_en/load_mem_addr/load_mem_data write port fills. On a start pulse it reads a contiguous range of words through the memory's synchronous read port and streams each word, tagged with its address, over a valid/ready interface. Benches and debug logic use it to confirm that a program load landed correctly.

Parameters:
ADDR_W, 5, address width; memory depth DEPTH = 2**ADDR_W (32 words)
DATA_W, 32, instruction word width

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle request to begin a dump; sampled only in IDLE
base_addr  input  ADDR_W  first word address; captured when start is accepted
count  input  ADDR_W+1  number of words to dump; captured when start is accepted
mem_rd_en  output  1  memory read strobe
mem_rd_addr  output  ADDR_W  memory read address
mem_rd_data  input  DATA_W  read data, valid exactly 1 cycle after mem_rd_en
out_valid  output  1  out_data, out_addr and out_last are valid
out_ready  input  1  consumer accepts the word when out_valid && out_ready
out_data  output  DATA_W  dumped word
out_addr  output  ADDR_W  address of out_data
out_last  output  1  high with the final word of the dump
busy  output  1  high in every state except IDLE
done  output  1  single-cycle pulse when the dump completes

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; all outputs 0, including mem_rd_en, mem_rd_addr, out_* , busy and done. Internal pointer and remaining-count registers are also 0.
- Reset asserted mid-dump aborts the dump immediately. No done pulse is produced. After release the block sits in IDLE.
- start accepted: start=1 while in IDLE.
  - Latch ptr=base_addr.
  - Latch rem = min(count, DEPTH); counts 33..63 clamp to 32.
- start while busy is ignored, with no side effects.
- count=0: go IDLE->DONE. done pulses on the cycle after start. No memory read and no out_valid.
- States and transitions:
  - IDLE: on an accepted start with rem>0, go to ISSUE.
  - ISSUE (1 cycle): mem_rd_en=1, mem_rd_addr=ptr. Go to CAPTURE.
  - CAPTURE (1 cycle): mem_rd_en=0. Register mem_rd_data into out_data and ptr into out_addr. Set out_last=(rem==1). Set out_valid=1 from the next cycle. Go to OUT.
  - OUT: hold out_valid/out_data/out_addr/out_last stable until out_ready=1.
    - On handshake: out_valid->0, ptr=ptr+1 mod DEPTH, rem=rem-1.
    - If the handshake was on the last word, go to DONE; otherwise go to ISSUE.
  - DONE (1 cycle): done=1, busy=1. Go to IDLE.
- mem_rd_en is high only in ISSUE. One read is issued per word. No speculative reads.
- Latency: start at cycle t gives first out_valid at cycle t+3. With out_ready held high, the block sustains 1 word per 3 cycles. done rises 1 cycle after the last handshake.
- Address wrap: ptr increments modulo DEPTH. Example: base 30, count 4 reads addresses 30, 31, 0, 1.
- out_ready is ignored whenever out_valid=0. out_valid never depends combinationally on out_ready.
- out_last is 0 whenever out_valid=0.

Test Plan:
- Load mem[0..31]=32'h1000_0000+i through load_mem_*. Then start base=0, count=32, out_ready=1 -> 32 words 0x10000000..0x1000001F at out_addr 0..31. out_last only on word 31. One done pulse, 1 cycle after the last handshake.
- base=30, count=4 -> out_addr sequence 30, 31, 0, 1 with matching data. mem_rd_addr shows the same wrap.
- count=0 -> done pulses 1 cycle after start. mem_rd_en and out_valid stay 0. busy is high for exactly 1 cycle.
- count=6'd40, base=5 -> exactly 32 words; the last word has out_addr=4.
- Backpressure: hold out_ready=0 for 7 cycles on word 2 of a base=8, count=3 dump -> out_data/out_addr stay stable at 0x10000009/9. No extra mem_rd_en pulses. A second start pulse during the dump is ignored.
- Assert rst_n=0 while in OUT mid-dump -> all outputs go to 0 immediately and done never pulses. A new start after reset dumps correctly from its new base.
